// File: rtl/pleiads_dl_pkg.sv
// Shared types and size constants for the pleiads ROM download sequencer.
// The optional DL_CHECKSUM_EN build adds an image checksum accumulator in pleiads_dl_ctrl.
package pleiads_dl_pkg;

    localparam int unsigned ADDR_W         = 25;
    localparam int unsigned OFF_W          = 16;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned CNT_W          = 17;
    localparam int unsigned CSUM_W         = 16;

    localparam int unsigned DEF_PROG_SIZE  = 16384;
    localparam int unsigned DEF_FG_SIZE    = 4096;
    localparam int unsigned DEF_BG_SIZE    = 4096;
    localparam int unsigned DEF_PROM_SIZE  = 512;
    localparam int unsigned DEF_HOLD_CYC   = 1024;

    localparam int unsigned DEF_FG_BASE    = DEF_PROG_SIZE;
    localparam int unsigned DEF_BG_BASE    = DEF_FG_BASE + DEF_FG_SIZE;
    localparam int unsigned DEF_PROM_BASE  = DEF_BG_BASE + DEF_BG_SIZE;
    localparam int unsigned DEF_TOTAL      = DEF_PROM_BASE + DEF_PROM_SIZE;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_ERR
    } dl_state_t;

    typedef enum logic [2:0] {
        RG_NONE,
        RG_PROG,
        RG_FG,
        RG_BG,
        RG_PROM
    } dl_region_t;

    typedef struct packed {
        dl_region_t         region;
        logic [OFF_W-1:0]   offset;
    } dl_dec_t;

    function automatic int unsigned dl_total(input int unsigned prog, input int unsigned fg,
                                             input int unsigned bg, input int unsigned prom);
        return prog + fg + bg + prom;
    endfunction

endpackage

// File: rtl/pleiads_region_dec.sv
// Combinational decode of the flat download address into a ROM region and local offset.
module pleiads_region_dec
    import pleiads_dl_pkg::*;
#(
    parameter int unsigned PROG_SIZE = DEF_PROG_SIZE,
    parameter int unsigned FG_SIZE   = DEF_FG_SIZE,
    parameter int unsigned BG_SIZE   = DEF_BG_SIZE,
    parameter int unsigned PROM_SIZE = DEF_PROM_SIZE
) (
    input  logic [ADDR_W-1:0] i_addr,
    output dl_dec_t           o_dec
);

    localparam int unsigned FG_BASE   = PROG_SIZE;
    localparam int unsigned BG_BASE   = FG_BASE + FG_SIZE;
    localparam int unsigned PROM_BASE = BG_BASE + BG_SIZE;
    localparam int unsigned TOTAL     = dl_total(PROG_SIZE, FG_SIZE, BG_SIZE, PROM_SIZE);

    always_comb begin
        o_dec.region = RG_NONE;
        o_dec.offset = '0;
        if (i_addr < ADDR_W'(FG_BASE)) begin
            o_dec.region = RG_PROG;
            o_dec.offset = OFF_W'(i_addr);
        end else if (i_addr < ADDR_W'(BG_BASE)) begin
            o_dec.region = RG_FG;
            o_dec.offset = OFF_W'(i_addr - ADDR_W'(FG_BASE));
        end else if (i_addr < ADDR_W'(PROM_BASE)) begin
            o_dec.region = RG_BG;
            o_dec.offset = OFF_W'(i_addr - ADDR_W'(BG_BASE));
        end else if (i_addr < ADDR_W'(TOTAL)) begin
            o_dec.region = RG_PROM;
            o_dec.offset = OFF_W'(i_addr - ADDR_W'(PROM_BASE));
        end
    end

endmodule

// File: rtl/pleiads_dl_ctrl.sv
// ROM download sequencer: region writes, image completeness tracking and core reset ownership.
// Define DL_CHECKSUM_EN to accumulate a 16-bit byte sum of the loaded image on checksum.
module pleiads_dl_ctrl
    import pleiads_dl_pkg::*;
#(
    parameter int unsigned PROG_SIZE = DEF_PROG_SIZE,
    parameter int unsigned FG_SIZE   = DEF_FG_SIZE,
    parameter int unsigned BG_SIZE   = DEF_BG_SIZE,
    parameter int unsigned PROM_SIZE = DEF_PROM_SIZE,
    parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dn_download,
    input  logic              dn_wr,
    input  logic [ADDR_W-1:0] dn_addr,
    input  logic [DATA_W-1:0] dn_data,
    input  logic              reset_req,
    output logic [OFF_W-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              we_prog,
    output logic              we_fg,
    output logic              we_bg,
    output logic              we_prom,
    output logic              core_reset,
    output logic              load_ok,
    output logic              load_err,
    output logic [CSUM_W-1:0] checksum
);

    localparam int unsigned TOTAL  = dl_total(PROG_SIZE, FG_SIZE, BG_SIZE, PROM_SIZE);
    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    dl_state_t          r_state, w_next;
    dl_dec_t            w_dec;
    logic [CNT_W-1:0]   r_cnt;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_ovf;
    logic               r_core_reset, r_load_ok, r_load_err;
    logic               r_we_prog, r_we_fg, r_we_bg, r_we_prom;
    logic [OFF_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic               w_accept, w_load_entry, w_in_range, w_sat;

    pleiads_region_dec #(
        .PROG_SIZE (PROG_SIZE),
        .FG_SIZE   (FG_SIZE),
        .BG_SIZE   (BG_SIZE),
        .PROM_SIZE (PROM_SIZE)
    ) u_dec (
        .i_addr (dn_addr),
        .o_dec  (w_dec)
    );

    assign w_accept     = dn_wr & dn_download;
    assign w_load_entry = dn_download & (r_state != ST_LOAD);
    assign w_in_range   = (w_dec.region != RG_NONE);
    assign w_sat        = (r_cnt == '1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_BOOT: if (dn_download) w_next = ST_LOAD;
            ST_LOAD: begin
                if (!dn_download)
                    w_next = (r_cnt == CNT_W'(TOTAL) && !r_ovf) ? ST_HOLD : ST_ERR;
            end
            ST_HOLD: begin
                if (dn_download)                     w_next = ST_LOAD;
                else if (!reset_req && r_hold == '0) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (dn_download)    w_next = ST_LOAD;
                else if (reset_req) w_next = ST_HOLD;
            end
            ST_ERR:  if (dn_download) w_next = ST_LOAD;
            default: w_next = ST_BOOT;
        endcase
    end

    // State, core reset and hold stretch; core_reset follows the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_BOOT;
            r_core_reset <= 1'b1;
            r_hold       <= '0;
        end else begin
            r_state      <= w_next;
            r_core_reset <= (w_next != ST_RUN);
            if (w_next == ST_HOLD && (r_state != ST_HOLD || reset_req))
                r_hold <= HOLD_W'(HOLD_CYC - 1);
            else if (r_state == ST_HOLD && r_hold != '0)
                r_hold <= r_hold - HOLD_W'(1);
        end
    end

    // Byte count, overflow and load verdict; a byte on the LOAD entry cycle belongs to the new image.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_load_ok  <= 1'b0;
            r_load_err <= 1'b0;
        end else if (w_load_entry) begin
            r_cnt      <= w_accept ? CNT_W'(1) : '0;
            r_ovf      <= w_accept & ~w_in_range;
            r_load_ok  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            if (w_accept && !w_sat)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_accept && (!w_in_range || w_sat))
                r_ovf <= 1'b1;
            if (r_state == ST_LOAD && w_next == ST_HOLD)
                r_load_ok <= 1'b1;
            if (r_state == ST_LOAD && w_next == ST_ERR)
                r_load_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we_prog <= 1'b0;
            r_we_fg   <= 1'b0;
            r_we_bg   <= 1'b0;
            r_we_prom <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_we_prog <= w_accept && (w_dec.region == RG_PROG);
            r_we_fg   <= w_accept && (w_dec.region == RG_FG);
            r_we_bg   <= w_accept && (w_dec.region == RG_BG);
            r_we_prom <= w_accept && (w_dec.region == RG_PROM);
            if (w_accept && w_in_range) begin
                r_wr_addr <= w_dec.offset;
                r_wr_data <= dn_data;
            end
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [CSUM_W-1:0] r_csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_csum <= '0;
        else if (w_load_entry)
            r_csum <= (w_accept && w_in_range) ? CSUM_W'(dn_data) : '0;
        else if (r_state == ST_LOAD && w_accept && w_in_range)
            r_csum <= r_csum + CSUM_W'(dn_data);
    end

    assign checksum = r_csum;
`else
    assign checksum = '0;
`endif

    assign core_reset = r_core_reset;
    assign load_ok    = r_load_ok;
    assign load_err   = r_load_err;
    assign we_prog    = r_we_prog;
    assign we_fg      = r_we_fg;
    assign we_bg      = r_we_bg;
    assign we_prom    = r_we_prom;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;

endmodule

// File: tb/tb_pleiads_dl_ctrl.sv
// Bench for pleiads_dl_ctrl: region vector table, randomized loads checked every cycle
// against an event-based reference model, plus hand-written reset-stretch sequences.
module tb_pleiads_dl_ctrl;

    localparam int unsigned T_PROG  = 1024;
    localparam int unsigned T_FG    = 256;
    localparam int unsigned T_BG    = 256;
    localparam int unsigned T_PROM  = 512;
    localparam int unsigned T_HOLD  = 64;
    localparam int unsigned T_TOTAL = T_PROG + T_FG + T_BG + T_PROM;

    logic        clk = 1'b0;
    logic        reset;
    logic        dn_download, dn_wr, reset_req;
    logic [24:0] dn_addr;
    logic [7:0]  dn_data;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        we_prog, we_fg, we_bg, we_prom;
    logic        core_reset, load_ok, load_err;
    logic [15:0] checksum;

    always #5 clk = ~clk;

    pleiads_dl_ctrl #(
        .PROG_SIZE (T_PROG),
        .FG_SIZE   (T_FG),
        .BG_SIZE   (T_BG),
        .PROM_SIZE (T_PROM),
        .HOLD_CYC  (T_HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dn_download (dn_download),
        .dn_wr       (dn_wr),
        .dn_addr     (dn_addr),
        .dn_data     (dn_data),
        .reset_req   (reset_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .we_prog     (we_prog),
        .we_fg       (we_fg),
        .we_bg       (we_bg),
        .we_prom     (we_prom),
        .core_reset  (core_reset),
        .load_ok     (load_ok),
        .load_err    (load_err),
        .checksum    (checksum)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: image bookkeeping plus the clock edge at which core reset may drop.
    int          cyc;
    bit          m_loading, m_good, m_ovf, m_ok, m_err;
    int          m_release, m_cnt;
    logic [15:0] m_csum, m_waddr;
    logic [7:0]  m_wdata;
    logic [3:0]  m_we;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [3:0]  we;
        logic [15:0] off;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_loading = 0; m_good = 0; m_ovf = 0; m_ok = 0; m_err = 0;
        m_release = 0; m_cnt = 0; m_csum = '0; m_waddr = '0; m_wdata = '0; m_we = '0;
    endtask

    task automatic model_edge(input logic dl, input logic wr, input logic [24:0] a,
                              input logic [7:0] d, input logic rq);
        int ai;
        cyc++;
        m_we = '0;
        ai = int'(a);
        if (dl && !m_loading) begin
            m_loading = 1; m_good = 0; m_cnt = 0; m_ovf = 0; m_csum = '0; m_ok = 0; m_err = 0;
        end else if (!dl && m_loading) begin
            m_loading = 0;
            m_good    = (m_cnt == int'(T_TOTAL)) && !m_ovf;
            m_ok      = m_good;
            m_err     = !m_good;
            m_release = cyc + int'(T_HOLD);
        end else if (!dl && m_good && rq) begin
            m_release = cyc + int'(T_HOLD);
        end
        if (dl && wr) begin
            if (m_cnt < 131071) m_cnt++;
            else m_ovf = 1;
            if (a < 25'(T_TOTAL)) begin
                if (ai < int'(T_PROG)) begin
                    m_we = 4'b0001; m_waddr = 16'(ai);
                end else if (ai < int'(T_PROG + T_FG)) begin
                    m_we = 4'b0010; m_waddr = 16'(ai - int'(T_PROG));
                end else if (ai < int'(T_PROG + T_FG + T_BG)) begin
                    m_we = 4'b0100; m_waddr = 16'(ai - int'(T_PROG + T_FG));
                end else begin
                    m_we = 4'b1000; m_waddr = 16'(ai - int'(T_PROG + T_FG + T_BG));
                end
                m_wdata = d;
                m_csum  = m_csum + 16'(d);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    function automatic logic [15:0] exp_csum();
`ifdef DL_CHECKSUM_EN
        return m_csum;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic compare_all();
        check("core_reset", 32'(core_reset), 32'(m_loading || !m_good || (cyc < m_release)));
        check("we", 32'({we_prom, we_bg, we_fg, we_prog}), 32'(m_we));
        check("load_ok", 32'(load_ok), 32'(m_ok));
        check("load_err", 32'(load_err), 32'(m_err));
        check("checksum", 32'(checksum), 32'(exp_csum()));
        if (m_we != '0) begin
            check("wr_addr", 32'(wr_addr), 32'(m_waddr));
            check("wr_data", 32'(wr_data), 32'(m_wdata));
        end
    endtask

    task automatic step(input logic dl, input logic wr, input logic [24:0] a,
                        input logic [7:0] d, input logic rq);
        dn_download = dl; dn_wr = wr; dn_addr = a; dn_data = d; reset_req = rq;
        @(posedge clk);
        model_edge(dl, wr, a, d, rq);
        #1;
        compare_all();
    endtask

    function automatic logic [7:0] pick_data(input int a, input int mode);
        logic [31:0] av;
        av = 32'(a);
        case (mode)
            0:       return av[7:0];
            1:       return (a >= int'(T_TOTAL - T_PROM)) ? 8'hFF : 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    // Sequential download of bytes 0..n-1 with random idle gaps, optional stray byte, then fall.
    task automatic load(input int n, input int mode, input bit extra);
        int a;
        a = 0;
        while (a < n) begin
            if ($urandom_range(3) == 0) begin
                step(1'b1, 1'b0, 25'($urandom), 8'($urandom), 1'($urandom));
            end else begin
                step(1'b1, 1'b1, 25'(a), pick_data(a, mode), 1'b0);
                a++;
            end
        end
        if (extra) step(1'b1, 1'b1, 25'(T_TOTAL), 8'h5A, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_release(input string name);
        int k;
        k = 0;
        do begin
            step(1'b0, 1'b0, '0, '0, 1'b0);
            k++;
        end while (core_reset && k < 5 * int'(T_HOLD));
        check(name, 32'(k), 32'(T_HOLD));
    endtask

    initial begin
        tbl[0] = '{25'd0,                          8'h11, 4'b0001, 16'd0};
        tbl[1] = '{25'(T_PROG - 1),                8'h22, 4'b0001, 16'(T_PROG - 1)};
        tbl[2] = '{25'(T_PROG),                    8'h33, 4'b0010, 16'd0};
        tbl[3] = '{25'(T_PROG + T_FG - 1),         8'h44, 4'b0010, 16'(T_FG - 1)};
        tbl[4] = '{25'(T_PROG + T_FG),             8'h55, 4'b0100, 16'd0};
        tbl[5] = '{25'(T_PROG + T_FG + T_BG - 1),  8'h66, 4'b0100, 16'(T_BG - 1)};
        tbl[6] = '{25'(T_PROG + T_FG + T_BG),      8'h77, 4'b1000, 16'd0};
        tbl[7] = '{25'(T_TOTAL - 1),               8'h88, 4'b1000, 16'(T_PROM - 1)};
        tbl[8] = '{25'(T_TOTAL),                   8'h99, 4'b0000, 16'd0};
        tbl[9] = '{25'h1FF_FFFF,                   8'hAA, 4'b0000, 16'd0};

        reset = 1'b1;
        dn_download = 0; dn_wr = 0; dn_addr = '0; dn_data = '0; reset_req = 0;
        model_reset();
        #12;
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_we", 32'({we_prom, we_bg, we_fg, we_prog}), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_flags", 32'({load_ok, load_err}), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        reset = 1'b0;

        // Power-up idle with stray writes and reset requests, no download.
        for (int i = 0; i < 10000; i++)
            step(1'b0, 1'($urandom), 25'($urandom), 8'($urandom), 1'($urandom));
        check("idle_core_reset", 32'(core_reset), 32'd1);
        check("idle_load_ok", 32'(load_ok), 32'd0);

        // Region boundary vectors inside one short (hence failing) download.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, tbl[i].addr, tbl[i].data, 1'b0);
            check("tbl_we", 32'({we_prom, we_bg, we_fg, we_prog}), 32'(tbl[i].we));
            if (tbl[i].we != '0) begin
                check("tbl_off", 32'(wr_addr), 32'(tbl[i].off));
                check("tbl_data", 32'(wr_data), 32'(tbl[i].data));
            end
        end
        step(1'b0, 1'b0, '0, '0, 1'b0);
        check("tbl_load_err", 32'(load_err), 32'd1);

        // Full load, data = addr[7:0]; reset stretch measured from the download fall.
        load(int'(T_TOTAL), 0, 1'b0);
        check("full_load_ok", 32'(load_ok), 32'd1);
        wait_release("full_hold_len");

        // Short load lands in ERR; reset requests must not release the core.
        load(int'(T_TOTAL) - 88, 2, 1'b0);
        check("short_load_err", 32'(load_err), 32'd1);
        for (int i = 0; i < 200; i++) step(1'b0, 1'b0, '0, '0, 1'($urandom));
        check("short_core_reset", 32'(core_reset), 32'd1);
        load(int'(T_TOTAL), 2, 1'b0);
        check("recover_load_err", 32'(load_err), 32'd0);
        wait_release("recover_hold_len");

        // Full image plus one byte past the end.
        load(int'(T_TOTAL), 2, 1'b1);
        check("ovf_load_err", 32'(load_err), 32'd1);
        check("ovf_load_ok", 32'(load_ok), 32'd0);
        load(int'(T_TOTAL), 2, 1'b0);
        wait_release("pre_req_hold_len");

        // One-cycle reset request from RUN.
        step(1'b0, 1'b0, '0, '0, 1'b1);
        check("req_pulse_core_reset", 32'(core_reset), 32'd1);
        wait_release("req_pulse_hold_len");

        // Held reset request keeps the core in reset until the stretch after release.
        for (int i = 0; i < 3000; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
        check("req_held_core_reset", 32'(core_reset), 32'd1);
        wait_release("req_held_hold_len");

        // Random activity in RUN: ignored writes and occasional reset requests.
        for (int i = 0; i < 1500; i++)
            step(1'b0, 1'($urandom), 25'($urandom), 8'($urandom), ($urandom_range(199) == 0));

        // PROM of 0xFF, zeros elsewhere.
        load(int'(T_TOTAL), 1, 1'b0);
`ifdef DL_CHECKSUM_EN
        check("csum_prom", 32'(checksum), 32'(16'(T_PROM * 255)));
`else
        check("csum_prom", 32'(checksum), 32'd0);
`endif

        // Async reset in the middle of a download drops the partial image.
        for (int a = 0; a < 300; a++) step(1'b1, 1'b1, 25'(a), 8'($urandom), 1'b0);
        reset = 1'b1;
        #2;
        check("midrst_core_reset", 32'(core_reset), 32'd1);
        check("midrst_checksum", 32'(checksum), 32'd0);
        check("midrst_flags", 32'({load_ok, load_err}), 32'd0);
        check("midrst_we", 32'({we_prom, we_bg, we_fg, we_prog}), 32'd0);
        model_reset();
        dn_download = 0; dn_wr = 0;
        reset = 1'b0;
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, '0, '0, 1'($urandom));
        load(int'(T_TOTAL), 2, 1'b0);
        wait_release("final_hold_len");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
